// File: rtl/id_ex_pipeline_reg.sv
// rtl/id_ex_pipeline_reg.sv - ID/EX pipeline register with stall, flush and WB write-through
// Optional macro ID_EX_PERF_CNT_EN adds bubble_cnt/stall_cnt counter outputs.
module id_ex_pipeline_reg #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_EX,
  input  logic                flush_EX,
  input  logic                valid_ID,
  input  logic [XLEN-1:0]     pc_ID,
  input  logic [4:0]          rs1_addr_ID,
  input  logic [4:0]          rs2_addr_ID,
  input  logic [4:0]          rd_addr_ID,
  input  logic [XLEN-1:0]     rs1_data_ID,
  input  logic [XLEN-1:0]     rs2_data_ID,
  input  logic [XLEN-1:0]     imm_ID,
  input  logic                RegWrite_ID,
  input  logic                MemRead_ID,
  input  logic                MemWrite_ID,
  input  logic                MemToReg_ID,
  input  logic                ALUSrc_ID,
  input  logic                Branch_ID,
  input  logic                Jump_ID,
  input  logic [ALU_OP_W-1:0] alu_op_ID,
  input  logic                RegWrite_WB,
  input  logic [4:0]          rd_addr_WB,
  input  logic [XLEN-1:0]     wb_data_WB,
  output logic                valid_EX,
  output logic [XLEN-1:0]     pc_EX,
  output logic [4:0]          rs1_addr_EX,
  output logic [4:0]          rs2_addr_EX,
  output logic [4:0]          rd_addr_EX,
  output logic [XLEN-1:0]     rs1_data_EX,
  output logic [XLEN-1:0]     rs2_data_EX,
  output logic [XLEN-1:0]     imm_EX,
  output logic                RegWrite_EX,
  output logic                MemRead_EX,
  output logic                MemWrite_EX,
  output logic                MemToReg_EX,
  output logic                ALUSrc_EX,
  output logic                Branch_EX,
  output logic                Jump_EX,
  output logic [ALU_OP_W-1:0] alu_op_EX
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]         bubble_cnt,
  output logic [31:0]         stall_cnt
`endif
);

  logic                valid_d, valid_q;
  logic [XLEN-1:0]     pc_d, pc_q;
  logic [4:0]          rs1_addr_d, rs1_addr_q;
  logic [4:0]          rs2_addr_d, rs2_addr_q;
  logic [4:0]          rd_addr_d, rd_addr_q;
  logic [XLEN-1:0]     rs1_data_d, rs1_data_q;
  logic [XLEN-1:0]     rs2_data_d, rs2_data_q;
  logic [XLEN-1:0]     imm_d, imm_q;
  logic                reg_write_d, reg_write_q;
  logic                mem_read_d, mem_read_q;
  logic                mem_write_d, mem_write_q;
  logic                mem_to_reg_d, mem_to_reg_q;
  logic                alu_src_d, alu_src_q;
  logic                branch_d, branch_q;
  logic                jump_d, jump_q;
  logic [ALU_OP_W-1:0] alu_op_d, alu_op_q;

  // A retiring WB write is visible to a given source index; x0 never matches.
  logic wb_live;
  assign wb_live = RegWrite_WB && (rd_addr_WB != 5'd0);

  // Choose between bubble, hold (with write-through) and capture (with write-through).
  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    rs1_addr_d   = rs1_addr_q;
    rs2_addr_d   = rs2_addr_q;
    rd_addr_d    = rd_addr_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    imm_d        = imm_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    alu_src_d    = alu_src_q;
    branch_d     = branch_q;
    jump_d       = jump_q;
    alu_op_d     = alu_op_q;

    if (flush_EX || (!stall_EX && !valid_ID)) begin
      // Bubble: all-zero, so no forwarding or load-use match can arise from it.
      valid_d      = 1'b0;
      pc_d         = '0;
      rs1_addr_d   = '0;
      rs2_addr_d   = '0;
      rd_addr_d    = '0;
      rs1_data_d   = '0;
      rs2_data_d   = '0;
      imm_d        = '0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      alu_src_d    = 1'b0;
      branch_d     = 1'b0;
      jump_d       = 1'b0;
      alu_op_d     = '0;
    end else if (stall_EX) begin
      // Held instruction: pick up the producer retiring now, forwarding loses it next cycle.
      if (wb_live && (rd_addr_WB == rs1_addr_q)) rs1_data_d = wb_data_WB;
      if (wb_live && (rd_addr_WB == rs2_addr_q)) rs2_data_d = wb_data_WB;
    end else begin
      valid_d      = 1'b1;
      pc_d         = pc_ID;
      rs1_addr_d   = rs1_addr_ID;
      rs2_addr_d   = rs2_addr_ID;
      rd_addr_d    = rd_addr_ID;
      rs1_data_d   = (wb_live && (rd_addr_WB == rs1_addr_ID)) ? wb_data_WB : rs1_data_ID;
      rs2_data_d   = (wb_live && (rd_addr_WB == rs2_addr_ID)) ? wb_data_WB : rs2_data_ID;
      imm_d        = imm_ID;
      reg_write_d  = RegWrite_ID;
      mem_read_d   = MemRead_ID;
      mem_write_d  = MemWrite_ID;
      mem_to_reg_d = MemToReg_ID;
      alu_src_d    = ALUSrc_ID;
      branch_d     = Branch_ID;
      jump_d       = Jump_ID;
      alu_op_d     = alu_op_ID;
    end
  end

  // Pipeline state register; reset loads the bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      rs1_addr_q   <= '0;
      rs2_addr_q   <= '0;
      rd_addr_q    <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_q    <= 1'b0;
      branch_q     <= 1'b0;
      jump_q       <= 1'b0;
      alu_op_q     <= '0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      rs1_addr_q   <= rs1_addr_d;
      rs2_addr_q   <= rs2_addr_d;
      rd_addr_q    <= rd_addr_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_src_q    <= alu_src_d;
      branch_q     <= branch_d;
      jump_q       <= jump_d;
      alu_op_q     <= alu_op_d;
    end
  end

  assign valid_EX    = valid_q;
  assign pc_EX       = pc_q;
  assign rs1_addr_EX = rs1_addr_q;
  assign rs2_addr_EX = rs2_addr_q;
  assign rd_addr_EX  = rd_addr_q;
  assign rs1_data_EX = rs1_data_q;
  assign rs2_data_EX = rs2_data_q;
  assign imm_EX      = imm_q;
  assign RegWrite_EX = reg_write_q;
  assign MemRead_EX  = mem_read_q;
  assign MemWrite_EX = mem_write_q;
  assign MemToReg_EX = mem_to_reg_q;
  assign ALUSrc_EX   = alu_src_q;
  assign Branch_EX   = branch_q;
  assign Jump_EX     = jump_q;
  assign alu_op_EX   = alu_op_q;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt_d, bubble_cnt_q;
  logic [31:0] stall_cnt_d, stall_cnt_q;

  // Count bubble loads (flush or empty ID) and true hold edges; both wrap naturally.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (flush_EX || (!stall_EX && !valid_ID)) bubble_cnt_d = bubble_cnt_q + 32'd1;
    if (stall_EX && !flush_EX)                stall_cnt_d  = stall_cnt_q + 32'd1;
  end

  // Counter registers; reset edges are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule
